adc_uart_tx: RTL and testbench

- Serial transmit stage directly downstream of the MCP3201 ADC reader.
- Grants the reader permission to convert by holding `serial_ready` high, then waits for the reader's chip-select to return high, which marks the end of a conversion.
- On that event it drops `serial_ready`, waits for the reader to present its 8 output bits, latches them, and sends one 8N1 UART frame on `tx`, LSB first.
- It then re-grants `serial_ready` for the next conversion.

---
 rtl/adc_serial_pkg.sv | 21 ++
 rtl/adc_uart_tx_baud_tick_gen.sv | 39 +++
 rtl/adc_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_adc_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared types and constants for the ADC serial transmit stage.
package adc_serial_pkg;

    localparam int FRAME_DATA_BITS      = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int BIT_IDX_W            = $clog2(FRAME_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        DATA,
        STOP
    } state_e;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_uart_tx_baud_tick_gen.sv
// Free-running baud counter with synchronous clear; ticks on the last cycle of each bit.
module baud_tick_gen
    import adc_serial_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    localparam int CNT_W        = cnt_width(CLKS_PER_BIT)
) (
    input  logic             clk_serial,
    input  logic             rst_serial,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets a value before any condition, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_serial) begin
        if (rst_serial) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick  = (cnt_q == LAST);
    assign count = cnt_q;

endmodule

// File: rtl/adc_uart_tx.sv
// Waits for the MCP3201 reader to finish a conversion, latches its 8 output bits
// and sends them as one 8N1 UART frame, LSB first.
module adc_uart_tx
    import adc_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk_serial,
    input  logic rst_serial,
    input  logic chip_select_in,
    input  logic bit0_adc,
    input  logic bit1_adc,
    input  logic bit2_adc,
    input  logic bit3_adc,
    input  logic bit4_adc,
    input  logic bit5_adc,
    input  logic bit6_adc,
    input  logic bit7_adc,
    output logic serial_ready,
    output logic tx,
    output logic busy,
    output logic tx_done,
    output logic overrun
);

    localparam int CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST    = BIT_IDX_W'(FRAME_DATA_BITS - 1);
    localparam logic [CNT_W-1:0]     DONE_AT     = CNT_W'(CLKS_PER_BIT - 2);

    logic [FRAME_DATA_BITS-1:0] adc_bits;

    logic [SYNC_STAGES-1:0]                      cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][FRAME_DATA_BITS-1:0] data_sync_q, data_sync_d;
    logic                                        cs_prev_q, cs_prev_d;

    state_e                     state_q, state_d;
    logic [SETTLE_W-1:0]        settle_q, settle_d;
    logic [BIT_IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;

    logic tx_q, tx_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic overrun_q, overrun_d;

    logic             cs_sync;
    logic             cs_rise;
    logic             baud_clear;
    logic             baud_tick;
    logic [CNT_W-1:0] baud_count;

    assign adc_bits = {bit7_adc, bit6_adc, bit5_adc, bit4_adc,
                       bit3_adc, bit2_adc, bit1_adc, bit0_adc};

    assign cs_sync     = cs_sync_q[SYNC_STAGES-1];
    assign cs_rise     = cs_sync & ~cs_prev_q;
    assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], chip_select_in};
    assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], adc_bits};
    assign cs_prev_d   = cs_sync;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_serial (clk_serial),
        .rst_serial (rst_serial),
        .clear      (baud_clear),
        .tick       (baud_tick),
        .count      (baud_count)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        baud_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    shift_d    = data_sync_q[SYNC_STAGES-1];
                    baud_clear = 1'b1;
                    state_d    = START;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so the registered pins line up with state_q.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        ready_d   = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == STOP) && (baud_count == DONE_AT);
        overrun_d = cs_rise && (state_q != IDLE);
    end

    always_ff @(posedge clk_serial) begin
        if (rst_serial) begin
            // NOTE: synchroniser and edge history reset to 1 so a chip-select already high at reset is not an edge.
            cs_sync_q   <= '1;
            data_sync_q <= '1;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            settle_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            data_sync_q <= data_sync_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx           = tx_q;
    assign serial_ready = ready_q;
    assign busy         = busy_q;
    assign tx_done      = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Directed bench for adc_uart_tx at CLKS_PER_BIT=4, SETTLE_CYCLES=4, SYNC_STAGES=2.
module tb_adc_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic       clk_serial     = 1'b0;
    logic       rst_serial     = 1'b1;
    logic       chip_select_in = 1'b1;
    logic [7:0] adc_bits       = 8'h00;
    logic       serial_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_serial = ~clk_serial;

    adc_uart_tx #(
        .CLKS_PER_BIT  (CPB),
        .SETTLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_serial     (clk_serial),
        .rst_serial     (rst_serial),
        .chip_select_in (chip_select_in),
        .bit0_adc       (adc_bits[0]),
        .bit1_adc       (adc_bits[1]),
        .bit2_adc       (adc_bits[2]),
        .bit3_adc       (adc_bits[3]),
        .bit4_adc       (adc_bits[4]),
        .bit5_adc       (adc_bits[5]),
        .bit6_adc       (adc_bits[6]),
        .bit7_adc       (adc_bits[7]),
        .serial_ready   (serial_ready),
        .tx             (tx),
        .busy           (busy),
        .tx_done        (tx_done),
        .overrun        (overrun)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic send_conv(input logic [7:0] d);
        @(negedge clk_serial);
        adc_bits       = d;
        chip_select_in = 1'b0;
        repeat (16) @(negedge clk_serial);
        chip_select_in = 1'b1;
    endtask

    // line[0] is the start bit, line[1..8] data LSB first, line[9] the stop bit.
    task automatic expect_frame(input logic [9:0] line, input string name,
                                input bit check_timing,
                                input int cs_low_at, input int cs_high_at,
                                input int data_at, input logic [7:0] new_data,
                                input bit expect_overrun);
        int n;
        int ready_fall;
        bit seen;
        int bit_err;
        int busy_bad;
        int done_cnt;
        int done_at;
        int ovr_cnt;
        int ovr_at;
        n = 0; ready_fall = -1; seen = 0; bit_err = 0; busy_bad = 0;
        done_cnt = 0; done_at = -1; ovr_cnt = 0; ovr_at = -1;

        while (!seen && n < 40) begin
            @(negedge clk_serial);
            n++;
            if (ready_fall < 0 && serial_ready === 1'b0) ready_fall = n;
            if (tx === 1'b0) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s start_bit: no start bit after %0d cycles, want one", name, n);
            return;
        end
        if (check_timing) begin
            tests_run++;
            if (n !== 7) begin
                tests_failed++;
                $display("FAIL %s start_latency: got %0d cycles, want 7", name, n);
            end
            tests_run++;
            if (ready_fall !== 3) begin
                tests_failed++;
                $display("FAIL %s ready_fall: got cycle %0d, want 3", name, ready_fall);
            end
        end

        for (int j = 0; j < FRAME_CYC; j++) begin
            if (j > 0) @(negedge clk_serial);
            if (j % CPB == 0) bit_err = 0;
            if (tx !== line[j / CPB]) bit_err++;
            if (busy !== 1'b1) busy_bad++;
            if (tx_done === 1'b1) begin done_cnt++; done_at = j; end
            if (overrun === 1'b1) begin ovr_cnt++; ovr_at = j; end
            if (j % CPB == CPB - 1) begin
                tests_run++;
                if (bit_err != 0) begin
                    tests_failed++;
                    $display("FAIL %s frame_bit%0d: %0d cycles wrong, want tx=%b throughout",
                             name, j / CPB, bit_err, line[j / CPB]);
                end
            end
            if (j == cs_low_at)  chip_select_in = 1'b0;
            if (j == cs_high_at) chip_select_in = 1'b1;
            if (j == data_at)    adc_bits = new_data;
        end

        tests_run++;
        if (done_cnt !== 1 || done_at !== FRAME_CYC - 1) begin
            tests_failed++;
            $display("FAIL %s tx_done: got %0d pulses last at %0d, want 1 at %0d",
                     name, done_cnt, done_at, FRAME_CYC - 1);
        end
        tests_run++;
        if (busy_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s busy_in_frame: low for %0d cycles, want 0", name, busy_bad);
        end
        tests_run++;
        if (expect_overrun) begin
            if (ovr_cnt !== 1 || ovr_at !== 18) begin
                tests_failed++;
                $display("FAIL %s overrun: got %0d pulses last at %0d, want 1 at 18",
                         name, ovr_cnt, ovr_at);
            end
        end else if (ovr_cnt !== 0) begin
            tests_failed++;
            $display("FAIL %s overrun: got %0d pulses, want 0", name, ovr_cnt);
        end

        @(negedge clk_serial);
        tests_run++;
        if (serial_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s after_frame: ready=%b busy=%b tx=%b, want 1 0 1",
                     name, serial_ready, busy, tx);
        end
    endtask

    task automatic test_reset();
        rst_serial     = 1'b1;
        chip_select_in = 1'b1;
        repeat (3) @(negedge clk_serial);
        tests_run++;
        if (serial_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b, want 0", serial_ready);
        end
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: tx=%b busy=%b tx_done=%b overrun=%b, want 1 0 0 0",
                     tx, busy, tx_done, overrun);
        end
        rst_serial = 1'b0;
        @(negedge clk_serial);
        tests_run++;
        if (serial_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: got %b, want 1", serial_ready);
        end
        test_quiet("release_no_frame", 20);
    endtask

    task automatic test_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_serial);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL %s: %0d cycles with tx low or busy high, want 0", name, bad);
        end
    endtask

    task automatic test_basic_frame();
        send_conv(8'hA5);
        expect_frame({1'b1, 8'hA5, 1'b0}, "frame_a5", 1'b1, -1, -1, -1, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_conv(8'h00);
        expect_frame({1'b1, 8'h00, 1'b0}, "b2b_00", 1'b1, -1, -1, -1, 8'h00, 1'b0);
        send_conv(8'hFF);
        expect_frame({1'b1, 8'hFF, 1'b0}, "b2b_ff", 1'b1, -1, -1, -1, 8'h00, 1'b0);
    endtask

    task automatic test_overrun();
        send_conv(8'h3C);
        expect_frame({1'b1, 8'h3C, 1'b0}, "overrun_3c", 1'b0, 13, 15, -1, 8'h00, 1'b1);
        test_quiet("overrun_no_second_frame", 30);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        n = 0;
        send_conv(8'hC3);
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk_serial);
            n++;
        end
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_start: no start bit after %0d cycles, want one", n);
            return;
        end
        repeat (25) @(negedge clk_serial);
        rst_serial = 1'b1;
        @(negedge clk_serial);
        rst_serial = 1'b0;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || serial_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: tx=%b busy=%b ready=%b, want 1 0 0",
                     tx, busy, serial_ready);
        end
        @(negedge clk_serial);
        tests_run++;
        if (serial_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_ready: got %b, want 1", serial_ready);
        end
        test_quiet("midrst_not_resumed", 20);
        send_conv(8'h5A);
        expect_frame({1'b1, 8'h5A, 1'b0}, "midrst_next_5a", 1'b1, -1, -1, -1, 8'h00, 1'b0);
    endtask

    task automatic test_data_change_in_start();
        send_conv(8'h96);
        expect_frame({1'b1, 8'h96, 1'b0}, "latch_96", 1'b1, -1, -1, 1, 8'h69, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_data_change_in_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
